utf8_stream_encoder: RTL and testbench

- Takes one code point per valid/ready handshake and emits its UTF-8 byte sequence, one byte per handshake.
- Performs the code-point-to-byte direction, the opposite of the existing byte-to-code-point decode path; sits between the code-point side and the byte I/O pins.
- Flags invalid code points, either substituting U+FFFD or dropping them.
- Keeps a saturating error count.

---
 rtl/utf8_pkg.sv | 75 +++++++
 rtl/utf8_len_classify.sv | 49 ++++
 rtl/utf8_stream_encoder.sv | 161 ++++++++++++++++
 tb/tb_utf8_stream_encoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/utf8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : utf8_pkg
//  Purpose  : Shared constants, error-code enum and byte-building helper for
//             the UTF-8 stream encoder.
//  Config   : UTF8_EXT_RANGE_EN selects a 6-byte maximum sequence length
//             (5/6-byte forms), otherwise the maximum is 4 bytes.
//  Revision : 1.0  initial release
// ============================================================================
package utf8_pkg;

   localparam logic [31:0] CP_REPLACEMENT = 32'h0000_FFFD;
   localparam logic [31:0] CP_MAX_UNICODE = 32'h0010_FFFF;
   localparam logic [31:0] SURR_LO        = 32'h0000_D800;
   localparam logic [31:0] SURR_HI        = 32'h0000_DFFF;

   // Lead-byte prefixes by sequence length, and the continuation prefix
   localparam logic [7:0] LEAD1_PREFIX = 8'h00;
   localparam logic [7:0] LEAD2_PREFIX = 8'hC0;
   localparam logic [7:0] LEAD3_PREFIX = 8'hE0;
   localparam logic [7:0] LEAD4_PREFIX = 8'hF0;
   localparam logic [7:0] LEAD5_PREFIX = 8'hF8;
   localparam logic [7:0] LEAD6_PREFIX = 8'hFC;
   localparam logic [7:0] CONT_PREFIX  = 8'h80;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_SURROGATE = 2'd1,
      ERR_RANGE     = 2'd2
   } err_code_t;

`ifdef UTF8_EXT_RANGE_EN
   localparam int MAX_SEQ_LEN = 6;
`else
   localparam int MAX_SEQ_LEN = 4;
`endif

   function automatic logic [7:0] lead_prefix(input logic [2:0] len);
      logic [7:0] p;
      case (len)
         3'd2:    p = LEAD2_PREFIX;
         3'd3:    p = LEAD3_PREFIX;
         3'd4:    p = LEAD4_PREFIX;
         3'd5:    p = LEAD5_PREFIX;
         3'd6:    p = LEAD6_PREFIX;
         default: p = LEAD1_PREFIX;
      endcase
      return p;
   endfunction

   // Byte number idx (0 = lead) of the len-byte encoding of cp.
   // Positions at or beyond len return zero so unused slots stay clean.
   function automatic logic [7:0] seq_byte(input logic [31:0] cp,
                                           input logic [2:0]  len,
                                           input int          idx);
      logic [31:0] sh;
      logic [7:0]  b;
      b  = 8'h00;
      sh = 32'h0;
      if (idx < int'(len)) begin
         sh = cp >> (6 * (int'(len) - idx - 1));
         if (idx != 0) begin
            b = CONT_PREFIX | {2'b00, sh[5:0]};
         end else if (len == 3'd1) begin
            b = {1'b0, sh[6:0]};
         end else begin
            // payload bits in the lead shrink by one for each extra byte
            b = lead_prefix(len) | (sh[7:0] & (8'hFF >> (int'(len) + 1)));
         end
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/utf8_len_classify.sv
`default_nettype none
// ============================================================================
//  Module   : utf8_len_classify
//  Purpose  : Combinational classifier: code point -> UTF-8 length and error.
//             A length of 0 is returned whenever err_code is not ERR_NONE.
//  Ports    : cp_data   in  32  code point
//             chk_range in  1   1 = enforce Unicode range, reject surrogates
//             len       out 3   sequence length 1..MAX_SEQ_LEN, 0 if invalid
//             err_code  out 2   ERR_NONE / ERR_SURROGATE / ERR_RANGE
//  Config   : UTF8_EXT_RANGE_EN adds 5- and 6-byte classes when chk_range=0.
//  Revision : 1.0  initial release
// ============================================================================
module utf8_len_classify
   import utf8_pkg::*;
(
   input  logic [31:0] cp_data,
   input  logic        chk_range,
   output logic [2:0]  len,
   output err_code_t   err_code
);

   always_comb begin
      len      = 3'd0;
      err_code = ERR_NONE;
      if (chk_range && (cp_data >= SURR_LO) && (cp_data <= SURR_HI)) begin
         err_code = ERR_SURROGATE;
      end else if (chk_range && (cp_data > CP_MAX_UNICODE)) begin
         err_code = ERR_RANGE;
      end else if (cp_data < 32'h0000_0080) begin
         len = 3'd1;
      end else if (cp_data < 32'h0000_0800) begin
         len = 3'd2;
      end else if (cp_data < 32'h0001_0000) begin
         len = 3'd3;
      end else if (cp_data < 32'h0020_0000) begin
         len = 3'd4;
`ifdef UTF8_EXT_RANGE_EN
      end else if (!chk_range && (cp_data < 32'h0400_0000)) begin
         len = 3'd5;
      end else if (!chk_range && (cp_data < 32'h8000_0000)) begin
         len = 3'd6;
`endif
      end else begin
         err_code = ERR_RANGE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/utf8_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : utf8_stream_encoder
//  Purpose  : Accepts one code point per handshake and streams its UTF-8
//             encoding one byte per handshake, lead byte first. Invalid code
//             points are flagged, counted (saturating) and either replaced by
//             U+FFFD (REPLACE_EN=1) or dropped (REPLACE_EN=0).
//  Ports    : clk, rst (async, active-high)
//             chk_range                in   range/surrogate checking enable
//             cp_data/cp_valid/cp_ready     code-point input handshake
//             byte_data/valid/ready/last    byte output handshake
//             err_valid                out  one-cycle invalid pulse
//             err_code                 out  last acceptance's error code
//             err_count                out  saturating invalid count
//  Config   : UTF8_EXT_RANGE_EN enables 5/6-byte sequences (chk_range=0).
//  Revision : 1.0  initial release
// ============================================================================
module utf8_stream_encoder
   import utf8_pkg::*;
#(
   parameter int REPLACE_EN = 1,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                chk_range,
   input  logic [31:0]         cp_data,
   input  logic                cp_valid,
   output logic                cp_ready,
   output logic [7:0]          byte_data,
   output logic                byte_valid,
   input  logic                byte_ready,
   output logic                byte_last,
   output logic                err_valid,
   output logic [1:0]          err_code,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam int c_SHREG_W = MAX_SEQ_LEN * 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t               r_state,     w_state_nxt;
   logic [c_SHREG_W-1:0] r_shreg,     w_shreg_nxt;
   logic [2:0]           r_rem,       w_rem_nxt;
   logic                 r_err_valid, w_err_valid_nxt;
   err_code_t            r_err_code,  w_err_code_nxt;
   logic [ERRCNT_W-1:0]  r_err_count, w_err_count_nxt;

   logic [2:0]           w_len;
   err_code_t            w_err;
   logic [31:0]          w_cp_eff;
   logic [2:0]           w_len_eff;
   logic [c_SHREG_W-1:0] w_load;
   logic                 w_byte_valid;
   logic                 w_byte_last;
   logic                 w_accept;

   utf8_len_classify u_classify (
      .cp_data   (cp_data),
      .chk_range (chk_range),
      .len       (w_len),
      .err_code  (w_err)
   );

   assign w_byte_valid = (r_state == EMIT);
   assign w_byte_last  = w_byte_valid && (r_rem == 3'd1);

   // byte_ready feeds cp_ready combinationally so a new sequence can be
   // loaded on the same edge the previous last byte leaves.
   assign cp_ready = (r_state == IDLE) || (w_byte_last && byte_ready);
   assign w_accept = cp_valid && cp_ready;

   // Select what actually gets encoded for this code point
   always_comb begin
      w_cp_eff  = cp_data;
      w_len_eff = w_len;
      if (w_err != ERR_NONE) begin
         if (REPLACE_EN != 0) begin
            w_cp_eff  = CP_REPLACEMENT;
            w_len_eff = 3'd3;
         end else begin
            w_len_eff = 3'd0;
         end
      end
   end

   // Left-aligned sequence: lead byte sits in the top byte of the register
   always_comb begin
      w_load = '0;
      for (int i = 0; i < MAX_SEQ_LEN; i++) begin
         w_load[(MAX_SEQ_LEN-1-i)*8 +: 8] = seq_byte(w_cp_eff, w_len_eff, i);
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = r_shreg;
      w_rem_nxt       = r_rem;
      w_err_valid_nxt = 1'b0;
      w_err_code_nxt  = r_err_code;
      w_err_count_nxt = r_err_count;
      if (w_accept) begin
         w_err_code_nxt = w_err;
         if (w_err != ERR_NONE) begin
            w_err_valid_nxt = 1'b1;
            if (r_err_count != {ERRCNT_W{1'b1}}) begin
               w_err_count_nxt = r_err_count + 1'b1;
            end
         end
         if (w_len_eff != 3'd0) begin
            w_state_nxt = EMIT;
            w_shreg_nxt = w_load;
            w_rem_nxt   = w_len_eff;
         end else begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_rem_nxt   = 3'd0;
         end
      end else if (w_byte_valid && byte_ready) begin
         if (w_byte_last) begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_rem_nxt   = 3'd0;
         end else begin
            w_shreg_nxt = r_shreg << 8;
            w_rem_nxt   = r_rem - 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_rem       <= 3'd0;
         r_err_valid <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_shreg     <= w_shreg_nxt;
         r_rem       <= w_rem_nxt;
         r_err_valid <= w_err_valid_nxt;
         r_err_code  <= w_err_code_nxt;
         r_err_count <= w_err_count_nxt;
      end
   end

   assign byte_data  = r_shreg[c_SHREG_W-1 -: 8];
   assign byte_valid = w_byte_valid;
   assign byte_last  = w_byte_last;
   assign err_valid  = r_err_valid;
   assign err_code   = r_err_code;
   assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_utf8_stream_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_utf8_stream_encoder
//  Purpose  : Directed self-checking bench for utf8_stream_encoder. A second
//             instance with REPLACE_EN=0 covers the drop behaviour.
//  Config   : UTF8_EXT_RANGE_EN adds the 5/6-byte vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_utf8_stream_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        chk_range;
   logic [31:0] cp_data;
   logic        cp_valid;
   logic        nr_cp_valid;
   logic        byte_ready;

   logic        cp_ready,  nr_cp_ready;
   logic [7:0]  byte_data, nr_byte_data;
   logic        byte_valid, nr_byte_valid;
   logic        byte_last,  nr_byte_last;
   logic        err_valid,  nr_err_valid;
   logic [1:0]  err_code,   nr_err_code;
   logic [7:0]  err_count,  nr_err_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] cp_q[$];
   logic [8:0]  exp_q[$];

   always #5 clk = ~clk;

   utf8_stream_encoder #(.REPLACE_EN(1), .ERRCNT_W(8)) dut (
      .clk(clk), .rst(rst), .chk_range(chk_range),
      .cp_data(cp_data), .cp_valid(cp_valid), .cp_ready(cp_ready),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_last(byte_last), .err_valid(err_valid), .err_code(err_code),
      .err_count(err_count)
   );

   utf8_stream_encoder #(.REPLACE_EN(0), .ERRCNT_W(8)) dut_nr (
      .clk(clk), .rst(rst), .chk_range(chk_range),
      .cp_data(cp_data), .cp_valid(nr_cp_valid), .cp_ready(nr_cp_ready),
      .byte_data(nr_byte_data), .byte_valid(nr_byte_valid), .byte_ready(byte_ready),
      .byte_last(nr_byte_last), .err_valid(nr_err_valid), .err_code(nr_err_code),
      .err_count(nr_err_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {valid,last,data} compared as one value
   task automatic check_byte(input string tag, input logic [7:0] b, input logic last);
      check(tag, 64'({byte_valid, byte_last, byte_data}), 64'({1'b1, last, b}));
   endtask

   task automatic expect_b(input logic [7:0] b, input logic last);
      exp_q.push_back({last, b});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Streams cp_q with byte_ready=1, checking every byte against exp_q and
   // that no idle cycle appears once output has started.
   task automatic run_stream(input string tag, input logic chk, input int budget);
      bit started;
      int cyc;
      started    = 0;
      cyc        = 0;
      chk_range  = chk;
      byte_ready = 1'b1;
      while ((cp_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         cp_valid = (cp_q.size() > 0);
         cp_data  = (cp_q.size() > 0) ? cp_q[0] : 32'h0;
         @(negedge clk);
         if (byte_valid) begin
            started = 1;
            if (exp_q.size() > 0) begin
               check({tag, "_byte"}, 64'({byte_last, byte_data}), 64'(exp_q[0]));
               void'(exp_q.pop_front());
            end else begin
               check({tag, "_extra"}, 64'(byte_valid), 64'd0);
            end
         end else if (started && exp_q.size() > 0) begin
            check({tag, "_bubble"}, 64'(byte_valid), 64'd1);
         end
         if (cp_valid && cp_ready) void'(cp_q.pop_front());
         next_cycle();
         cyc++;
      end
      cp_valid = 1'b0;
      check({tag, "_drained"}, 64'(cp_q.size() + exp_q.size()), 64'd0);
      cp_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst         = 1'b1;
      chk_range   = 1'b1;
      cp_data     = 32'h0;
      cp_valid    = 1'b0;
      nr_cp_valid = 1'b0;
      byte_ready  = 1'b1;

      // ---------------- reset state ----------------
      next_cycle();
      check("rst_byte_valid", 64'(byte_valid), 64'd0);
      check("rst_byte_last",  64'(byte_last),  64'd0);
      check("rst_byte_data",  64'(byte_data),  64'd0);
      check("rst_err",        64'({err_valid, err_code, err_count}), 64'd0);
      check("rst_cp_ready",   64'(cp_ready),   64'd1);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // ---------------- back-to-back valid stream ----------------
      cp_q = '{32'h41, 32'hE9, 32'h20AC, 32'h1F600, 32'h7F, 32'h80, 32'hFFFE, 32'hE000};
      expect_b(8'h41, 1);
      expect_b(8'hC3, 0); expect_b(8'hA9, 1);
      expect_b(8'hE2, 0); expect_b(8'h82, 0); expect_b(8'hAC, 1);
      expect_b(8'hF0, 0); expect_b(8'h9F, 0); expect_b(8'h98, 0); expect_b(8'h80, 1);
      expect_b(8'h7F, 1);
      expect_b(8'hC2, 0); expect_b(8'h80, 1);
      expect_b(8'hEF, 0); expect_b(8'hBF, 0); expect_b(8'hBE, 1);
      expect_b(8'hEE, 0); expect_b(8'h80, 0); expect_b(8'h80, 1);
      run_stream("b2b", 1'b1, 60);
      check("b2b_no_err", 64'({err_code, err_count}), 64'd0);

      // surrogate with range checks disabled encodes normally
      cp_q = '{32'hD800};
      expect_b(8'hED, 0); expect_b(8'hA0, 0); expect_b(8'h80, 1);
      run_stream("surr_nochk", 1'b0, 20);
      check("surr_nochk_cnt", 64'({err_code, err_count}), 64'd0);

      // ---------------- backpressure hold ----------------
      chk_range  = 1'b1;
      cp_data    = 32'h20AC;
      cp_valid   = 1'b1;
      byte_ready = 1'b0;
      next_cycle();
      cp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_byte("stall_hold", 8'hE2, 1'b0);
         check("stall_cp_ready", 64'(cp_ready), 64'd0);
         next_cycle();
      end
      byte_ready = 1'b1;
      @(negedge clk); check_byte("stall_b0", 8'hE2, 1'b0); next_cycle();
      @(negedge clk); check_byte("stall_b1", 8'h82, 1'b0); next_cycle();
      @(negedge clk); check_byte("stall_b2", 8'hAC, 1'b1); next_cycle();
      @(negedge clk); check("stall_idle", 64'({byte_valid, cp_ready}), 64'b01);
      next_cycle();

      // ---------------- surrogate with replacement ----------------
      chk_range = 1'b1;
      cp_data   = 32'hD800;
      cp_valid  = 1'b1;
      next_cycle();
      cp_valid = 1'b0;
      @(negedge clk);
      check("surr_err", 64'({err_valid, err_code, err_count}), 64'({1'b1, 2'd1, 8'd1}));
      check_byte("surr_r0", 8'hEF, 1'b0);
      next_cycle();
      @(negedge clk);
      check("surr_pulse_end", 64'(err_valid), 64'd0);
      check_byte("surr_r1", 8'hBF, 1'b0);
      next_cycle();
      @(negedge clk); check_byte("surr_r2", 8'hBD, 1'b1); next_cycle();
      @(negedge clk);
      check("surr_done", 64'({byte_valid, err_code}), 64'({1'b0, 2'd1}));

      // ---------------- surrogate dropped (REPLACE_EN=0) ----------------
      next_cycle();
      nr_cp_valid = 1'b1;
      next_cycle();
      nr_cp_valid = 1'b0;
      @(negedge clk);
      check("drop_err", 64'({nr_err_valid, nr_err_code, nr_err_count}), 64'({1'b1, 2'd1, 8'd1}));
      check("drop_no_byte", 64'({nr_byte_valid, nr_cp_ready}), 64'b01);
      next_cycle();

      // ---------------- out of range ----------------
      cp_data  = 32'h110000;
      cp_valid = 1'b1;
      next_cycle();
      cp_valid = 1'b0;
      @(negedge clk);
      check("range_err", 64'({err_valid, err_code, err_count}), 64'({1'b1, 2'd2, 8'd2}));
      check_byte("range_r0", 8'hEF, 1'b0);
      next_cycle(); next_cycle(); next_cycle();
      check("range_drained", 64'(byte_valid), 64'd0);

      cp_q = '{32'h110000};
      expect_b(8'hF4, 0); expect_b(8'h90, 0); expect_b(8'h80, 0); expect_b(8'h80, 1);
      run_stream("range_nochk", 1'b0, 20);
      check("range_nochk_err", 64'({err_code, err_count}), 64'({2'd0, 8'd2}));

      // ---------------- saturation on the dropping instance ----------------
      chk_range   = 1'b1;
      cp_data     = 32'h110000;
      nr_cp_valid = 1'b1;
      for (int i = 0; i < 253; i++) next_cycle();
      check("sat_254", 64'(nr_err_count), 64'd254);
      for (int i = 0; i < 47; i++) next_cycle();
      nr_cp_valid = 1'b0;
      @(negedge clk);
      check("sat_255", 64'({nr_err_count, nr_err_code, nr_byte_valid}), 64'({8'd255, 2'd2, 1'b0}));
      next_cycle();

      // ---------------- async reset mid-sequence ----------------
      chk_range  = 1'b1;
      byte_ready = 1'b1;
      cp_data    = 32'h1F600;
      cp_valid   = 1'b1;
      next_cycle();
      cp_valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk); check_byte("rst_mid_pre", 8'h98, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid", 64'({byte_valid, cp_ready, err_count, byte_data}), 64'({1'b0, 1'b1, 8'd0, 8'd0}));
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_quiet", 64'({byte_valid, err_code}), 64'd0);
         next_cycle();
      end

`ifdef UTF8_EXT_RANGE_EN
      // ---------------- extended range ----------------
      cp_q = '{32'h7FFFFFFF, 32'h200000};
      expect_b(8'hFD, 0); expect_b(8'hBF, 0); expect_b(8'hBF, 0);
      expect_b(8'hBF, 0); expect_b(8'hBF, 0); expect_b(8'hBF, 1);
      expect_b(8'hF8, 0); expect_b(8'h88, 0); expect_b(8'h80, 0);
      expect_b(8'h80, 0); expect_b(8'h80, 1);
      run_stream("ext", 1'b0, 40);

      chk_range = 1'b0;
      cp_data   = 32'h80000000;
      cp_valid  = 1'b1;
      next_cycle();
      cp_valid = 1'b0;
      @(negedge clk);
      check("ext_range_err", 64'({err_valid, err_code}), 64'({1'b1, 2'd2}));
      next_cycle(); next_cycle(); next_cycle();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
